cla_add_scheduler: RTL
======================

CLA_ADD_SCHEDULER -- requirements
Module: cla_add_scheduler

Interface
REQ-001 Parameter: W, default 64, operand/sum width of the shared carry-lookahead adder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents a beat.
REQ-005 reqN_ready  output  1  scheduler accepts requester N's beat this cycle.
REQ-006 reqN_a, reqN_b  input  W  operand words.
REQ-007 reqN_cin  input  1  carry-in, used only on the first beat of a burst.
REQ-008 reqN_last  input  1  beat is the final word of a multi-word burst.
REQ-009 add_a, add_b  output  W  operands driven to the external combinational adder.
REQ-010 add_cin  output  1  carry-in driven to the adder.
REQ-011 add_sum  input  W; add_cout  input  1: adder results, valid in the same cycle.
REQ-012 rsp_valid  output  1; rsp_ready  input  1: result handshake.
REQ-013 rsp_id  output  1  requester of the result; rsp_sum  output  W; rsp_cout  output  1; rsp_last  output  1; rsp_beat  output  8  beat index within the burst.

Function
REQ-014 FSM states: IDLE (no burst open) and LOCK (burst open, grant fixed to lock_id).
REQ-015 Output slot free when rsp_valid=0 or rsp_ready=1; no beat accepted unless the slot is free.
REQ-016 IDLE grant: the single valid requester; if both valid, the requester named by the round-robin pointer rr.
REQ-017 LOCK grant: lock_id only; the other requester's ready stays 0 regardless of its valid.
REQ-018 reqN_ready = grant to N AND slot free; at most one ready high per cycle.
REQ-019 Accept = granted valid AND ready; add_a/add_b always reflect the granted requester's operands (don't-care when nothing is granted).
REQ-020 add_cin = reqN_cin in IDLE; add_cin = stored carry register cy in LOCK.
REQ-021 On accept: rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_id<=N, rsp_last<=reqN_last, rsp_beat<=beat counter, rsp_valid<=1; cy<=add_cout.
REQ-022 Latency: result visible exactly one cycle after acceptance; full throughput, one beat per cycle while rsp_ready=1.
REQ-023 Accept with last=0 in IDLE -> LOCK, lock_id<=N, beat counter<=1.
REQ-024 Accept with last=0 in LOCK -> stay in LOCK, beat counter increments, wrapping 255 -> 0.
REQ-025 Accept with last=1 (either state) -> IDLE, beat counter<=0, rr<=opposite of N.
REQ-026 Single-beat burst: last=1 accepted in IDLE, rsp_beat=0, rr toggles.
REQ-027 rsp_valid=1 and rsp_ready=0: all rsp_* outputs held stable, no accept.
REQ-028 rsp_valid=1, rsp_ready=1 and new accept in the same cycle: slot reloads, rsp_valid stays 1.
REQ-029 rsp_ready=1 with no accept: rsp_valid<=0 next cycle.
REQ-030 Gaps inside a burst (lock_id valid=0) keep LOCK, cy and the beat counter unchanged.
REQ-031 Sum arithmetic is modulo 2^W; the carry out of each beat is carried only into the next beat of the same burst.

Reset
REQ-032 rst high: state=IDLE, rr=0, lock_id=0, cy=0, beat counter=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_last=0, rsp_beat=0 immediately, independent of clk.
REQ-033 Reset mid-burst abandons the burst; no partial result is emitted afterwards; the first beat after reset uses reqN_cin.
REQ-034 reqN_ready=0 while rst is high.

Verification
REQ-035 Single beat, req0: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_beat=0, rsp_last=1.
REQ-036 128-bit add, req1: beat0 a=FFFF_FFFF_FFFF_FFFF, b=1, last=0; beat1 a=0, b=0, last=1 -> rsp_sum 0 then 1, rsp_cout 1 then 0, rsp_beat 0 then 1.
REQ-037 Both valid from reset with single beats -> grants alternate 0,1,0,1 across four consecutive cycles.
REQ-038 req0 opens a 3-beat burst while req1 is valid throughout -> req1_ready=0 until req0's last beat is accepted, and req1 is granted in the following cycle.
REQ-039 rsp_ready held 0 for 3 cycles after one accept -> rsp_* stable, both readies 0; rsp_ready=1 -> the next beat is accepted that same cycle.
REQ-040 rst asserted mid-burst (after beat1 of 3) -> outputs at reset values at once; a new req0 beat with cin=1, a=0, b=0 gives rsp_sum=1.

Source files
------------

// File: rtl/cla_add_scheduler_if.sv
// Bundle between two adder requesters, the shared external adder
// and the result consumer of cla_add_scheduler.
interface cla_add_scheduler_if #(
  parameter int W = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req0_last;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic         req1_last;

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_last;
  logic [7:0]   rsp_beat;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req0_cin, req0_last,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    input  req1_cin, req1_last,
    output req1_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output rsp_valid, rsp_id, rsp_sum,
    output rsp_cout, rsp_last, rsp_beat,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req0_cin, req0_last,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    output req1_cin, req1_last,
    input  req1_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  rsp_valid, rsp_id, rsp_sum,
    input  rsp_cout, rsp_last, rsp_beat,
    output rsp_ready
  );
endinterface

// File: rtl/cla_add_scheduler.sv
// Two-requester scheduler for one shared carry-lookahead adder.
// Multi-word bursts lock the grant and chain carry beat to beat.
module cla_add_scheduler #(
  parameter int W = 64
) (
  input logic               clk,
  input logic               rst,
  cla_add_scheduler_if.slave bus
);
  typedef enum logic {IDLE, LOCK} state_e;

  state_e       state_q, state_d;
  logic         rr_q, rr_d;
  logic         lock_id_q, lock_id_d;
  logic         cy_q, cy_d;
  logic [7:0]   beat_q, beat_d;

  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_sum_q, rsp_sum_d;
  logic         rsp_cout_q, rsp_cout_d;
  logic         rsp_id_q, rsp_id_d;
  logic         rsp_last_q, rsp_last_d;
  logic [7:0]   rsp_beat_q, rsp_beat_d;

  logic slot_free;
  logic gnt;
  logic gnt_vld;
  logic gvalid;
  logic glast;
  logic accept;

  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt     = (bus.req0_valid & bus.req1_valid) ?
                  rr_q : bus.req1_valid;
      end
      LOCK: begin
        gnt_vld = 1'b1;
        gnt     = lock_id_q;
      end
    endcase
  end

  assign slot_free = ~rsp_valid_q | bus.rsp_ready;
  assign gvalid    = gnt ? bus.req1_valid : bus.req0_valid;
  assign glast     = gnt ? bus.req1_last  : bus.req0_last;

  assign bus.req0_ready = ~rst & gnt_vld & ~gnt & slot_free;
  assign bus.req1_ready = ~rst & gnt_vld &  gnt & slot_free;
  assign accept = gvalid & (gnt ? bus.req1_ready : bus.req0_ready);

  // In a locked burst the carry comes from the previous beat.
  assign bus.add_a   = gnt ? bus.req1_a : bus.req0_a;
  assign bus.add_b   = gnt ? bus.req1_b : bus.req0_b;
  assign bus.add_cin = (state_q == LOCK) ? cy_q :
                       (gnt ? bus.req1_cin : bus.req0_cin);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_id_d   = lock_id_q;
    cy_d        = cy_q;
    beat_d      = beat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;
    rsp_beat_d  = rsp_beat_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = bus.add_sum;
      rsp_cout_d  = bus.add_cout;
      rsp_id_d    = gnt;
      rsp_last_d  = glast;
      rsp_beat_d  = beat_q;
      cy_d        = bus.add_cout;
      if (glast) begin
        state_d = IDLE;
        beat_d  = 8'd0;
        rr_d    = ~gnt;
      end else if (state_q == IDLE) begin
        state_d   = LOCK;
        lock_id_d = gnt;
        beat_d    = 8'd1;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      lock_id_q   <= 1'b0;
      cy_q        <= 1'b0;
      beat_q      <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_beat_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_id_q   <= lock_id_d;
      cy_q        <= cy_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
      rsp_beat_q  <= rsp_beat_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_beat  = rsp_beat_q;
endmodule
